// File: rtl/fixed_mul_seq_if.sv
// Operand/result handshake bundle for fixed_mul_seq.
// Signal names keep the arithmetic-stage _i/_o naming so stages chain by name.
interface fixed_mul_seq_if #(
    parameter int N = 32
);
    logic         valid_i;
    logic [N-1:0] opA_i;
    logic [N-1:0] opB_i;
    logic         busy_o;
    logic         ready_o;
    logic [N-1:0] result_o;
    logic         overflow_o;

    modport master (
        output valid_i, opA_i, opB_i,
        input  busy_o, ready_o, result_o, overflow_o
    );

    modport slave (
        input  valid_i, opA_i, opB_i,
        output busy_o, ready_o, result_o, overflow_o
    );
endinterface

// File: rtl/fixed_mul_seq.sv
// Sequential sign-magnitude Q-format multiplier.
// Performs one shift-add step per clock and saturates the magnitude on overflow.
module fixed_mul_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    fixed_mul_seq_if.slave bus
);
    localparam int W  = 2 * N - 2;
    localparam int CW = $clog2(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

    state_t        state_reg;
    logic          sign_reg;
    logic [W-1:0]  mcand_reg;
    logic [W-1:0]  acc_reg;
    logic [N-2:0]  mplier_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0]  result_reg;
    logic          ready_reg;
    logic          overflow_reg;
    logic          busy_reg;

    logic [W-1:0]  scaled_next;
    logic          sat_next;
    logic [N-2:0]  mag_next;

    // Anything above the magnitude field after the Q shift means saturation.
    always_comb begin
        scaled_next = acc_reg >> Q;
        sat_next    = |scaled_next[W-1:N-1];
        mag_next    = sat_next ? '1 : scaled_next[N-2:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            sign_reg     <= 1'b0;
            mcand_reg    <= '0;
            acc_reg      <= '0;
            mplier_reg   <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            ready_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.valid_i) begin
                        sign_reg   <= bus.opA_i[N-1] ^ bus.opB_i[N-1];
                        mcand_reg  <= W'(bus.opA_i[N-2:0]);
                        mplier_reg <= bus.opB_i[N-2:0];
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(N - 2)) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    // A zero magnitude always leaves with a clear sign bit.
                    result_reg   <= {sign_reg & (|mag_next), mag_next};
                    overflow_reg <= sat_next;
                    ready_reg    <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o     = busy_reg;
    assign bus.ready_o    = ready_reg;
    assign bus.result_o   = result_reg;
    assign bus.overflow_o = overflow_reg;
endmodule
